lut_stream: RTL and testbench

- Multi-channel pixel look-up-table stage for the streaming video path.
- Each channel of an incoming pixel beat indexes its own LUT of 2**DATA_WIDTH entries; the looked-up values leave on an AXI4-Stream-style output.
- Fixed latency, full backpressure, and a host table-write port.
- Tables are double-banked so that new contents take effect exactly at a frame boundary (see Optional Feature).

---
 rtl/lut_stream.sv | 147 ++++++++++++++
 tb/tb_lut_stream.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_stream.sv
// Multi-channel pixel LUT stage: registered table read, output register, one stall enable for both stages.
// Define LUT_STREAM_BANK_SWAP_EN for double-banked tables that swap on the next start-of-frame beat.
module lut_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 3,
  parameter int CHAN_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic                           wr_i,
  input  logic [CHAN_W-1:0]              wr_chan_i,
  input  logic [DATA_WIDTH-1:0]          wr_addr_i,
  input  logic [DATA_WIDTH-1:0]          wr_data_i,
  input  logic                           swap_req_i,
  output logic                           swap_pending_o,
  input  logic                           bypass_i,
  input  logic [CHANNELS*DATA_WIDTH-1:0] s_tdata_i,
  input  logic                           s_tvalid_i,
  output logic                           s_tready_o,
  input  logic                           s_tuser_i,
  input  logic                           s_tlast_i,
  output logic [CHANNELS*DATA_WIDTH-1:0] m_tdata_o,
  output logic                           m_tvalid_o,
  input  logic                           m_tready_i,
  output logic                           m_tuser_o,
  output logic                           m_tlast_o
);
  localparam int PIX_W = CHANNELS * DATA_WIDTH;

  // Asserts asynchronously, releases two edges after rst_n_i rises.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  logic ce;
  logic accept;
  assign ce         = !m_tvalid_o || m_tready_i;
  assign s_tready_o = ce;
  assign accept     = s_tvalid_i && ce;

`ifdef LUT_STREAM_BANK_SWAP_EN
  localparam int ADDR_W = DATA_WIDTH + 1;

  logic active_bank;
  logic swap_now;
  logic rd_bank;

  // A request arriving with the SOF beat counts, so that beat already reads the new bank.
  assign swap_now = accept && s_tuser_i && (swap_pending_o || swap_req_i);
  assign rd_bank  = active_bank ^ swap_now;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      active_bank    <= 1'b0;
      swap_pending_o <= 1'b0;
    end else if (swap_now) begin
      active_bank    <= ~active_bank;
      swap_pending_o <= 1'b0;
    end else if (swap_req_i) begin
      swap_pending_o <= 1'b1;
    end
  end
`else
  localparam int ADDR_W = DATA_WIDTH;

  logic unused_swap_req;
  assign unused_swap_req = swap_req_i;
  assign swap_pending_o  = 1'b0;
`endif

  // Entries are stored XORed with their address, so an all-zero power-up RAM reads as identity.
  logic [PIX_W-1:0] rd_word;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic [DATA_WIDTH-1:0] ram [2**ADDR_W];
    logic [DATA_WIDTH-1:0] rd_q;
    logic [ADDR_W-1:0]     rd_addr;
    logic [ADDR_W-1:0]     wr_addr;
    logic                  wr_en;

`ifdef LUT_STREAM_BANK_SWAP_EN
    assign rd_addr = {rd_bank, s_tdata_i[c*DATA_WIDTH +: DATA_WIDTH]};
    assign wr_addr = {~active_bank, wr_addr_i};
`else
    assign rd_addr = s_tdata_i[c*DATA_WIDTH +: DATA_WIDTH];
    assign wr_addr = wr_addr_i;
`endif
    // Out-of-range channel numbers match no table and are dropped.
    assign wr_en = wr_i && (wr_chan_i == CHAN_W'(c));

    // NOTE: table RAM has no reset branch; resetting it would prevent block-RAM inference.
    always_ff @(posedge clk_i) begin
      if (wr_en) ram[wr_addr] <= wr_data_i ^ wr_addr_i;
      if (ce)    rd_q         <= ram[rd_addr];
    end

    assign rd_word[c*DATA_WIDTH +: DATA_WIDTH] = rd_q;
  end

  // Stage 1 sideband: travels alongside the registered table read.
  logic             s1_valid;
  logic             s1_user;
  logic             s1_last;
  logic             s1_bypass;
  logic [PIX_W-1:0] s1_pix;
  logic [PIX_W-1:0] lut_pix;

  // NOTE: all state updates use non-blocking assignment so both stages shift on the same edge.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_user   <= 1'b0;
      s1_last   <= 1'b0;
      s1_bypass <= 1'b0;
      s1_pix    <= '0;
    end else if (ce) begin
      s1_valid  <= s_tvalid_i;
      s1_user   <= s_tuser_i;
      s1_last   <= s_tlast_i;
      s1_bypass <= bypass_i;
      s1_pix    <= s_tdata_i;
    end
  end

  // Decoding the address-XOR storage: each channel's read address is its own input pixel.
  assign lut_pix = rd_word ^ s1_pix;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      m_tvalid_o <= 1'b0;
      m_tuser_o  <= 1'b0;
      m_tlast_o  <= 1'b0;
      m_tdata_o  <= '0;
    end else if (ce) begin
      m_tvalid_o <= s1_valid;
      m_tuser_o  <= s1_user;
      m_tlast_o  <= s1_last;
      m_tdata_o  <= s1_bypass ? s1_pix : lut_pix;
    end
  end

endmodule

// File: tb/tb_lut_stream.sv
// Self-checking bench for lut_stream: table-level model with an expected-beat queue plus directed literal checks.
// Build with or without LUT_STREAM_BANK_SWAP_EN; bank-dependent expectations follow the same macro.
module tb_lut_stream;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  wr_chan = '0;
  logic [7:0]  wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        swap_req = 1'b0;
  logic        swap_pending;
  logic        bypass = 1'b0;
  logic [23:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tuser = 1'b0;
  logic        s_tlast = 1'b0;
  logic [23:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic        m_tuser;
  logic        m_tlast;

  int checks = 0;
  int errors = 0;

  lut_stream dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .wr_i(wr), .wr_chan_i(wr_chan), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .swap_req_i(swap_req), .swap_pending_o(swap_pending), .bypass_i(bypass),
    .s_tdata_i(s_tdata), .s_tvalid_i(s_tvalid), .s_tready_o(s_tready),
    .s_tuser_i(s_tuser), .s_tlast_i(s_tlast),
    .m_tdata_o(m_tdata), .m_tvalid_o(m_tvalid), .m_tready_i(m_tready),
    .m_tuser_o(m_tuser), .m_tlast_o(m_tlast)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: plain table arrays, bank state, and a queue of expected {user,last,data} beats.
  logic [7:0]  tbl [2][3][256];
  logic        mdl_active = 1'b0;
  logic        mdl_pending = 1'b0;
  logic [25:0] exp_q [$];
  logic        hold_valid = 1'b0;
  logic [25:0] hold_val;

  initial begin
    for (int b = 0; b < 2; b++)
      for (int c = 0; c < 3; c++)
        for (int i = 0; i < 256; i++) tbl[b][c][i] = 8'(i);
  end

  always @(negedge clk) begin
    logic        acc;
    logic        sof_swap;
    logic        use_bank;
    logic        wbank;
    logic [23:0] e;
    logic [7:0]  x;
    logic [25:0] got;
    if (!rst_n) begin
      exp_q.delete();
      mdl_active  = 1'b0;
      mdl_pending = 1'b0;
      hold_valid  = 1'b0;
    end else begin
      got = {m_tuser, m_tlast, m_tdata};
      if (hold_valid) begin
        check("stall_valid_held", m_tvalid, 1);
        check("stall_data_held", got, hold_val);
      end
      hold_valid = m_tvalid && !m_tready;
      hold_val   = got;
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) check("unexpected_beat", 1, 0);
        else check("stream_beat", got, exp_q.pop_front());
      end
      check("ready_rule", s_tready, !m_tvalid || m_tready);
`ifdef LUT_STREAM_BANK_SWAP_EN
      check("swap_pending", swap_pending, mdl_pending);
`else
      check("swap_pending", swap_pending, 0);
`endif
      acc = s_tvalid && s_tready;
`ifdef LUT_STREAM_BANK_SWAP_EN
      sof_swap = acc && s_tuser && (mdl_pending || swap_req);
      use_bank = mdl_active ^ sof_swap;
      wbank    = !mdl_active;
`else
      sof_swap = 1'b0;
      use_bank = 1'b0;
      wbank    = 1'b0;
`endif
      if (acc) begin
        for (int c = 0; c < 3; c++) begin
          x = s_tdata[c*8 +: 8];
          e[c*8 +: 8] = bypass ? x : tbl[use_bank][c][x];
        end
        exp_q.push_back({s_tuser, s_tlast, e});
      end
      if (wr && wr_chan < 2'd3) tbl[wbank][wr_chan][wr_addr] = wr_data;
`ifdef LUT_STREAM_BANK_SWAP_EN
      if (sof_swap) begin
        mdl_active  = !mdl_active;
        mdl_pending = 1'b0;
      end else if (swap_req) begin
        mdl_pending = 1'b1;
      end
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [23:0] d, input logic u, input logic l, input logic b);
    int  n = 0;
    logic acc = 1'b0;
    s_tdata = d; s_tuser = u; s_tlast = l; bypass = b; s_tvalid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = s_tready;
      tick();
      n++;
    end
    if (!acc) check("send_timeout", 0, 1);
    s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0; bypass = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [23:0] exp);
    int   n = 0;
    logic seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      seen = m_tvalid && m_tready;
      if (!seen) begin
        tick();
        n++;
      end
    end
    if (!seen) check({name, "_timeout"}, 0, 1);
    else begin
      check(name, m_tdata, exp);
      tick();
    end
  endtask

  task automatic pulse_swap();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    logic       done;

    // Reset state
    tick(); tick();
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_tuser", m_tuser, 0);
    check("rst_tlast", m_tlast, 0);
    check("rst_pending", swap_pending, 0);
    rst_n = 1'b1;
    tick(); tick(); tick();

    // Identity pass, 4x2 frame back to back, output exactly 2 cycles after presentation
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        v = 8'(i);
        s_tvalid = 1'b1; s_tdata = {3{v}}; s_tuser = (i == 0); s_tlast = (i == 3 || i == 7);
      end else begin
        s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
      end
      @(negedge clk);
      if (i >= 2) begin
        v = 8'(i - 2);
        check("id_valid", m_tvalid, 1);
        check("id_data", m_tdata, {3{v}});
        check("id_user", m_tuser, (i == 2));
        check("id_last", m_tlast, (i == 5 || i == 9));
      end else begin
        check("id_latency_idle", m_tvalid, 0);
      end
      tick();
    end
    drain("id_drain");

    // Inverting table on channel 1, plus an ignored write to channel 3
    for (int i = 0; i < 256; i++) begin
      wr = 1'b1; wr_chan = 2'd1; wr_addr = 8'(i); wr_data = 8'(255 - i);
      tick();
    end
    wr_chan = 2'd3; wr_addr = 8'h10; wr_data = 8'h55;
    tick();
    wr = 1'b0;
    pulse_swap();
    tick();
`ifdef LUT_STREAM_BANK_SWAP_EN
    check("inv_pending_armed", swap_pending, 1);
`else
    check("inv_pending_armed", swap_pending, 0);
`endif
    send(24'h302010, 1'b1, 1'b0, 1'b0);
    check("inv_pending_cleared", swap_pending, 0);
    expect_out("inv_sof", 24'h30DF10);

    // Frame-aligned swap: request mid-frame, takes effect on next SOF
    send(24'h050505, 1'b1, 1'b0, 1'b0);
    expect_out("fa_old0", 24'h05FA05);
    send(24'h060606, 1'b0, 1'b0, 1'b0);
    expect_out("fa_old1", 24'h06F906);
    pulse_swap();
    send(24'h404040, 1'b0, 1'b0, 1'b0);
    expect_out("fa_old2", 24'h40BF40);
    send(24'h414141, 1'b0, 1'b1, 1'b0);
    expect_out("fa_old3", 24'h41BE41);
    send(24'h404040, 1'b1, 1'b0, 1'b0);
`ifdef LUT_STREAM_BANK_SWAP_EN
    expect_out("fa_new_sof", 24'h404040);
`else
    expect_out("fa_new_sof", 24'h40BF40);
`endif
    check("fa_pending_cleared", swap_pending, 0);

    // Backpressure: random downstream ready, continuous input, 64 beats
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 64; i++)
          send(24'($urandom), (i == 0), (i % 8 == 7), 1'b0);
        done = 1'b1;
      end
      begin
        while (!done) begin
          tick();
          m_tready = 1'($urandom_range(0, 1));
        end
        m_tready = 1'b1;
      end
    join
    drain("bp_drain");

    // Bypass on odd beats; swap request coincides with the SOF beat
    for (int i = 0; i < 8; i++) begin
      v = 8'(i * 17 + 3);
      swap_req = (i == 0);
      send({3{v}}, (i == 0), (i == 7), i[0]);
      swap_req = 1'b0;
      if (i[0]) expect_out("byp_pass", {3{v}});
      else      expect_out("byp_lut", {v, ~v, v});
    end
    check("byp_pending_clear", swap_pending, 0);

    // Reset mid-frame with an output beat stalled and a swap pending
    pulse_swap();
    send(24'h777777, 1'b0, 1'b0, 1'b0);
    m_tready = 1'b0;
    tick();
    check("rstmid_pre_valid", m_tvalid, 1);
`ifdef LUT_STREAM_BANK_SWAP_EN
    check("rstmid_pre_pending", swap_pending, 1);
`endif
    rst_n = 1'b0;
    #1;
    check("rstmid_tvalid", m_tvalid, 0);
    check("rstmid_pending", swap_pending, 0);
    check("rstmid_tdata", m_tdata, 0);
    tick();
    m_tready = 1'b1;
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    send(24'h302010, 1'b1, 1'b0, 1'b0);
`ifdef LUT_STREAM_BANK_SWAP_EN
    expect_out("rstmid_bank0", 24'h302010);
`else
    expect_out("rstmid_bank0", 24'h30DF10);
`endif
    drain("final_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
